jpeg_zz_reader: RTL and testbench

JPEG_ZZ_READER -- requirements
Module: jpeg_zz_reader

---
 rtl/jpeg_zz_reader_pkg.sv | 43 ++++
 rtl/jpeg_zz_fifo.sv | 74 +++++++
 rtl/jpeg_zz_reader.sv | 153 +++++++++++++++
 tb/tb_jpeg_zz_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_zz_reader_pkg.sv
// Shared JPEG zigzag-reader definitions: zigzag order, RAM layout, FSM states, beat record.
// Optional zero-run suppression is enabled by defining JPEG_ZZ_RLE_EN.
package jpeg_zz_reader_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 32;
    localparam int unsigned ADDR_W          = 5;
    localparam int unsigned COEF_W          = 16;
    localparam int unsigned POS_W           = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } zz_state_e;

    typedef struct packed {
        logic [COEF_W-1:0] coef;
        logic [POS_W-1:0]  pos;
        logic [POS_W-1:0]  run;
    } zz_beat_t;

    // Natural (row-major) index for each zigzag position.
    localparam logic [5:0] ZZ_TABLE [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Two coefficients per word: even natural index in the upper half.
    function automatic logic [ADDR_W-1:0] zz_word_addr(input logic [POS_W-1:0] pos);
        return ZZ_TABLE[pos][5:1];
    endfunction

    function automatic logic zz_low_half(input logic [POS_W-1:0] pos);
        return ZZ_TABLE[pos][0];
    endfunction

endpackage

// File: rtl/jpeg_zz_fifo.sv
// Two-entry fall-through FIFO for returned coefficients, with a credit count that
// covers both stored entries and reads still in flight.
module jpeg_zz_fifo
    import jpeg_zz_reader_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     issue_i,
    input  logic     ret_i,
    input  logic     push_i,
    input  zz_beat_t din_i,
    input  logic     pop_i,
    output zz_beat_t dout_o,
    output logic     valid_o,
    output logic     credit_o
);

    zz_beat_t   r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_cnt;
    logic [1:0] r_out;

    logic       w_empty;
    logic       w_store;
    logic       w_take;
    logic [2:0] w_occ;
    logic [2:0] w_free;

    assign w_empty = (r_cnt == 2'd0);
    // Data popped the same cycle it returns into an empty FIFO is never stored.
    assign w_store = push_i && !(w_empty && pop_i);
    assign w_take  = pop_i && !w_empty;
    assign w_occ   = {1'b0, r_cnt} + {1'b0, r_out};
    assign w_free  = {2'b00, pop_i} + {2'b00, (ret_i && !push_i)};

    // Head selection with bypass of returning data and the issue credit.
    always_comb begin
        valid_o  = 1'b0;
        dout_o   = '0;
        credit_o = 1'b0;
        if (w_empty) begin
            valid_o = push_i;
            dout_o  = din_i;
        end else begin
            valid_o = 1'b1;
            dout_o  = r_mem[r_rptr];
        end
        credit_o = (w_occ < (w_free + 3'd2));
    end

    // Storage, pointers, entry count and outstanding-read count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
            r_out    <= 2'd0;
        end else begin
            if (w_store) begin
                r_mem[r_wptr] <= din_i;
                r_wptr        <= ~r_wptr;
            end
            if (w_take) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, w_store} - {1'b0, w_take};
            r_out <= r_out + {1'b0, issue_i} - {1'b0, ret_i};
        end
    end

endmodule

// File: rtl/jpeg_zz_reader.sv
// Reads one 8x8 block of quantized coefficients from RAM in zigzag order and streams it out.
// Define JPEG_ZZ_RLE_EN to suppress zero coefficients at positions 1..62 and report run lengths.
module jpeg_zz_reader
    import jpeg_zz_reader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [31:0]       ram_dat_i,
    output logic [COEF_W-1:0] coef_o,
    output logic [POS_W-1:0]  pos_o,
    output logic [POS_W-1:0]  run_o,
    output logic              last_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o
);

    zz_state_e         r_state;
    zz_state_e         w_state_nxt;
    logic [POS_W-1:0]  r_pos;
    logic [POS_W-1:0]  r_ret_pos;
    logic              r_ret_vld;
    logic              r_ret_sel;
    logic              r_done;

    logic              w_start;
    logic              w_issue;
    logic              w_credit;
    logic              w_keep;
    logic              w_push;
    logic              w_pop;
    logic              w_last;
    logic              w_fifo_valid;
    logic [COEF_W-1:0] w_ret_coef;
    logic [POS_W-1:0]  w_run;
    zz_beat_t          w_din;
    zz_beat_t          w_dout;

    // A start during the done pulse is still inside the block and is ignored.
    assign w_start    = start_i && (r_state == IDLE) && !r_done;
    assign w_issue    = (r_state == RUN) && w_credit;
    assign w_ret_coef = r_ret_sel ? ram_dat_i[15:0] : ram_dat_i[31:16];
    assign w_push     = r_ret_vld && w_keep;
    assign w_din      = {w_ret_coef, r_ret_pos, w_run};
    assign w_pop      = w_fifo_valid && ready_i;
    assign w_last     = w_fifo_valid && (w_dout.pos == 6'd63);

`ifdef JPEG_ZZ_RLE_EN
    logic [POS_W-1:0] r_run;

    assign w_keep = (w_ret_coef != 16'd0) || (r_ret_pos == 6'd0) || (r_ret_pos == 6'd63);
    assign w_run  = r_run;

    // Zeros skipped since the previous emitted coefficient; the count travels with the beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run <= 6'd0;
        end else if (w_push) begin
            r_run <= 6'd0;
        end else if (r_ret_vld) begin
            r_run <= r_run + 6'd1;
        end else begin
            r_run <= r_run;
        end
    end
`else
    assign w_keep = 1'b1;
    assign w_run  = 6'd0;
`endif

    // Next-state logic for the block sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) w_state_nxt = RUN;
                else         w_state_nxt = IDLE;
            end
            RUN: begin
                if (w_issue && (r_pos == 6'd63)) w_state_nxt = FLUSH;
                else                             w_state_nxt = RUN;
            end
            FLUSH: begin
                if (w_pop && w_last) w_state_nxt = IDLE;
                else                 w_state_nxt = FLUSH;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sequencer state, read position and the halfword select carried with each read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_pos     <= 6'd0;
            r_ret_vld <= 1'b0;
            r_ret_pos <= 6'd0;
            r_ret_sel <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret_vld <= w_issue;
            r_done    <= (r_state == FLUSH) && w_pop && w_last;
            if (w_start) begin
                r_pos <= 6'd0;
            end else if (w_issue) begin
                r_pos     <= r_pos + 6'd1;
                r_ret_pos <= r_pos;
                r_ret_sel <= zz_low_half(r_pos);
            end else begin
                r_pos <= r_pos;
            end
        end
    end

    jpeg_zz_fifo u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .issue_i  (w_issue),
        .ret_i    (r_ret_vld),
        .push_i   (w_push),
        .din_i    (w_din),
        .pop_i    (w_pop),
        .dout_o   (w_dout),
        .valid_o  (w_fifo_valid),
        .credit_o (w_credit)
    );

    // Output drive; beat fields read as zero whenever no beat is offered.
    always_comb begin
        ram_en_o   = w_issue;
        ram_addr_o = zz_word_addr(r_pos);
        valid_o    = w_fifo_valid;
        busy_o     = (r_state != IDLE) || r_done;
        done_o     = r_done;
        if (w_fifo_valid) begin
            coef_o = w_dout.coef;
            pos_o  = w_dout.pos;
            run_o  = w_dout.run;
            last_o = w_last;
        end else begin
            coef_o = 16'd0;
            pos_o  = 6'd0;
            run_o  = 6'd0;
            last_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_jpeg_zz_reader.sv
// Self-checking bench for jpeg_zz_reader: table of block runs plus reset/restart sequences,
// with a scoreboard of expected beats built from an independent zigzag walk.
module tb_jpeg_zz_reader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        ram_en_o;
    logic [4:0]  ram_addr_o;
    logic [31:0] ram_dat_i;
    logic [15:0] coef_o;
    logic [5:0]  pos_o;
    logic [5:0]  run_o;
    logic        last_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic        done_o;

    always #5 clk_i = ~clk_i;

    jpeg_zz_reader dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .ram_en_o   (ram_en_o),
        .ram_addr_o (ram_addr_o),
        .ram_dat_i  (ram_dat_i),
        .coef_o     (coef_o),
        .pos_o      (pos_o),
        .run_o      (run_o),
        .last_o     (last_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

`ifdef JPEG_ZZ_RLE_EN
    localparam bit RLE = 1'b1;
`else
    localparam bit RLE = 1'b0;
`endif

    typedef struct {
        logic [15:0] coef;
        logic [5:0]  pos;
        logic [5:0]  run;
        logic        last;
    } beat_t;

    typedef struct {
        int pat;
        int rmode;
        int exp_beats;
        int exp_done;
        int restart_at;
        int reset_at;
    } vec_t;

    logic [31:0] mem [32];
    logic [15:0] nat [64];
    int          tb_zz [64];
    beat_t       exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // One-cycle read latency RAM; garbage when not enabled.
    always @(posedge clk_i) begin
        ram_dat_i <= ram_en_o ? mem[ram_addr_o] : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic longint pack(input beat_t b);
        return longint'({b.coef, b.pos, b.run, b.last});
    endfunction

    function automatic void build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int rmin = (s > 7) ? s - 7 : 0;
            int rmax = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = rmin; r <= rmax; r++) begin tb_zz[k] = 8 * r + (s - r); k++; end
            end else begin
                for (int r = rmax; r >= rmin; r--) begin tb_zz[k] = 8 * r + (s - r); k++; end
            end
        end
    endfunction

    function automatic void load_pattern(input int pat);
        for (int n = 0; n < 64; n++) begin
            case (pat)
                0:       nat[n] = 16'(n);
                1:       nat[n] = (n == 0) ? 16'h0040 : ((n == 9) ? 16'hFFFE : 16'h0000);
                default: nat[n] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000;
            endcase
        end
        for (int w = 0; w < 32; w++) mem[w] = {nat[2 * w], nat[2 * w + 1]};
    endfunction

    function automatic int build_expected();
        int    run = 0;
        beat_t b;
        exp_q.delete();
        for (int p = 0; p < 64; p++) begin
            logic [15:0] v = nat[tb_zz[p]];
            if (RLE && p != 0 && p != 63 && v == 16'h0000) begin
                run++;
            end else begin
                b.coef = v; b.pos = 6'(p); b.run = 6'(run); b.last = (p == 63);
                exp_q.push_back(b);
                run = 0;
            end
        end
        return exp_q.size();
    endfunction

    task automatic run_block(input vec_t v);
        int    exp_n;
        int    beats = 0;
        int    cyc = 0;
        int    done_cnt = 0;
        int    post = 0;
        bit    stalled = 1'b0;
        bit    restarted = 1'b0;
        bit    done_seen = 1'b0;
        bit    aborted = 1'b0;
        beat_t held;
        beat_t got;
        beat_t e;
        load_pattern(v.pat);
        exp_n = build_expected();
        if (v.exp_beats >= 0) exp_n = v.exp_beats;
        ready_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc = 1;
        while (cyc < 400) begin
            case (v.rmode)
                0:       ready_i = 1'b1;
                1:       ready_i = (cyc % 2 == 1);
                default: ready_i = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clk_i);
            got.coef = coef_o; got.pos = pos_o; got.run = run_o; got.last = last_o;
            if (done_seen) begin
                post++;
                check("idle_after_done", longint'({busy_o, ram_en_o, valid_o, done_o}), 0);
                if (post >= 3) break;
            end else begin
                check("busy_in_block", longint'(busy_o), 1);
            end
            if (stalled) begin
                check("stall_valid_held", longint'(valid_o), 1);
                check("stall_beat_stable", pack(got), pack(held));
            end
            if (valid_o && v.reset_at >= 0 && beats == v.reset_at) begin
                rst_ni = 1'b0;
                #1;
                check("reset_async_outputs",
                      longint'({valid_o, busy_o, ram_en_o, done_o, last_o, coef_o, pos_o, run_o}), 0);
                aborted = 1'b1;
                break;
            end
            if (valid_o && ready_i) begin
                if (beats == 0) begin
                    check("first_coef_word0_hi", longint'(coef_o), longint'(mem[0][31:16]));
                    if (v.rmode == 0) check("first_valid_latency", cyc, 2);
                end
                if (exp_q.size() == 0) begin
                    check("extra_beat", longint'(pos_o), 64);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", pack(got), pack(e));
                end
                beats++;
            end
            stalled = valid_o && !ready_i;
            held = got;
            if (done_o && !done_seen) begin
                done_seen = 1'b1;
                if (v.exp_done > 0) check("done_cycle", cyc, v.exp_done);
            end
            if (done_o) done_cnt++;
            @(posedge clk_i); #1;
            cyc++;
            start_i = (v.restart_at >= 0 && beats == v.restart_at && !restarted);
            if (start_i) restarted = 1'b1;
        end
        start_i = 1'b0;
        if (aborted) begin
            repeat (2) begin
                @(negedge clk_i);
                check("no_done_in_reset", longint'({done_o, busy_o, valid_o}), 0);
            end
            @(posedge clk_i); #1;
            rst_ni = 1'b1;
            check("beats_before_reset", beats, v.reset_at);
            exp_q.delete();
        end else begin
            check("done_seen", longint'(done_seen), 1);
            check("done_count", done_cnt, 1);
            check("beat_count", beats, exp_n);
            check("scoreboard_empty", exp_q.size(), 0);
        end
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{pat: 0, rmode: 0, exp_beats: 64, exp_done: 66, restart_at: -1, reset_at: -1};
        vecs[1] = '{pat: 0, rmode: 1, exp_beats: 64, exp_done: 0, restart_at: -1, reset_at: -1};
        vecs[2] = '{pat: 0, rmode: 0, exp_beats: 64, exp_done: 66, restart_at: 10, reset_at: -1};
        vecs[3] = '{pat: 0, rmode: 0, exp_beats: 64, exp_done: 0, restart_at: -1, reset_at: 30};
        vecs[4] = '{pat: 0, rmode: 0, exp_beats: 64, exp_done: 66, restart_at: -1, reset_at: -1};
        vecs[5] = '{pat: 1, rmode: 0, exp_beats: (RLE ? 3 : 64), exp_done: 66, restart_at: -1, reset_at: -1};
        vecs[6] = '{pat: 1, rmode: 1, exp_beats: (RLE ? 3 : 64), exp_done: 0, restart_at: -1, reset_at: -1};
        vecs[7] = '{pat: 2, rmode: 2, exp_beats: -1, exp_done: 0, restart_at: -1, reset_at: -1};

        build_zz();
        rst_ni  = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b0;
        #2;
        check("reset_valid", longint'(valid_o), 0);
        check("reset_busy", longint'(busy_o), 0);
        check("reset_done", longint'(done_o), 0);
        check("reset_ram_en", longint'(ram_en_o), 0);
        check("reset_beat_fields", longint'({last_o, coef_o, pos_o, run_o}), 0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_after_release", longint'({valid_o, busy_o, ram_en_o, done_o}), 0);
        @(posedge clk_i); #1;

        for (int i = 0; i < 8; i++) begin
            run_block(vecs[i]);
            repeat (2) @(posedge clk_i);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
